// File: rtl/handshake_arb_pkg.sv
// Shared types and helpers for the handshake store arbiter.
package handshake_arb_pkg;

  localparam int DefaultNumPorts = 5;
  localparam int DefaultIdWidth  = $clog2(DefaultNumPorts);

  // Requester index for the default five-port configuration.
  typedef logic [DefaultIdWidth-1:0] id_t;

  // Index after cur, wrapping at numPorts.
  function automatic int rrNext(input int cur, input int numPorts);
    return (cur + 1 >= numPorts) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/handshake_store_tag_fifo.sv
// Circular buffer of requester ids for writes issued to memory but not yet
// completed. The head is the requester owed the next completion.
module handshake_store_tag_fifo
  import handshake_arb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int ID_WIDTH = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic [ID_WIDTH-1:0] pushId,
  input  logic                pop,
  output logic [ID_WIDTH-1:0] headId,
  output logic                full,
  output logic                empty
);

  localparam int PtrWidth   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CountWidth = $clog2(DEPTH + 1);

  logic [ID_WIDTH-1:0]   slots [DEPTH];
  logic [PtrWidth-1:0]   rdPtr;
  logic [PtrWidth-1:0]   wrPtr;
  logic [CountWidth-1:0] count;
  logic                  doPush;
  logic                  doPop;

  // Pointer increment that also wraps for non power-of-two depths.
  function automatic logic [PtrWidth-1:0] bump(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(DEPTH - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // A full buffer refuses a push even when a pop happens in the same cycle.
  assign doPush = push & !full;
  assign doPop  = pop & !empty;
  assign full   = (count == CountWidth'(DEPTH));
  assign empty  = (count == '0);
  assign headId = slots[rdPtr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= bump(wrPtr);
      if (doPop)  rdPtr <= bump(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + CountWidth'(1);
        2'b01:   count <= count - CountWidth'(1);
        default: count <= count;
      endcase
    end
  end

  // Id storage; contents are only meaningful between push and pop.
  always_ff @(posedge clock) begin
    if (doPush) slots[wrPtr] <= pushId;
  end

endmodule

// File: rtl/handshake_store_arbiter.sv
// Round-robin arbiter sharing one handshake memory store port between
// NUM_PORTS store requesters. Writes are serialized onto the port and each
// completion is steered back to the requester that issued it, in issue order.
//
// Handshake rule on every channel: a transfer happens in a cycle where valid
// and ready are both 1; a producer holds valid and its payload until then.
module handshake_store_arbiter
  import handshake_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 5,
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_stData,
  input  logic [NUM_PORTS-1:0]                 req_stData_valid,
  output logic [NUM_PORTS-1:0]                 req_stData_ready,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_stAddr,
  input  logic [NUM_PORTS-1:0]                 req_stAddr_valid,
  output logic [NUM_PORTS-1:0]                 req_stAddr_ready,
  output logic [NUM_PORTS-1:0]                 req_stDone_valid,
  input  logic [NUM_PORTS-1:0]                 req_stDone_ready,
  output logic [DATA_WIDTH-1:0]                mem_stData,
  output logic [ADDR_WIDTH-1:0]                mem_stAddr,
  output logic                                 mem_st_valid,
  input  logic                                 mem_st_ready,
  input  logic                                 mem_stDone_valid,
  output logic                                 mem_stDone_ready,
  output logic                                 protocol_error
);

  localparam int IdWidth = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] eligible;
  logic [IdWidth-1:0]   rrPtr;
  logic [IdWidth-1:0]   lockId;
  logic                 lockValid;
  logic [IdWidth-1:0]   granted;
  logic                 anyGrant;
  int                   scanIdx;
  logic                 tagFull;
  logic                 tagEmpty;
  logic [IdWidth-1:0]   headId;
  logic                 issueFire;
  logic                 doneFire;

  // A requester competes only once both its address and data are offered.
  assign eligible = req_stAddr_valid & req_stData_valid;

  // Grant: keep a stalled requester while it stays eligible, otherwise take
  // the first eligible index scanning upward from rrPtr with wrap-around.
  always_comb begin
    granted  = rrPtr;
    anyGrant = 1'b0;
    scanIdx  = 0;
    if (lockValid && eligible[lockId]) begin
      granted  = lockId;
      anyGrant = 1'b1;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        scanIdx = int'(rrPtr) + k;
        if (scanIdx >= NUM_PORTS) scanIdx = scanIdx - NUM_PORTS;
        if (!anyGrant && eligible[scanIdx]) begin
          granted  = IdWidth'(scanIdx);
          anyGrant = 1'b1;
        end
      end
    end
  end

  // No new write is offered while every tag slot is in use.
  assign mem_st_valid = anyGrant & !tagFull;
  assign issueFire    = mem_st_valid & mem_st_ready;
  assign mem_stData   = req_stData[granted];
  assign mem_stAddr   = req_stAddr[granted];

  // Only the granted requester sees ready, and only when the write lands.
  always_comb begin
    req_stAddr_ready = '0;
    if (anyGrant && mem_st_ready && !tagFull) req_stAddr_ready[granted] = 1'b1;
  end
  assign req_stData_ready = req_stAddr_ready;

  // Rotate priority to just past the requester that was served.
  always_ff @(posedge clock) begin
    if (reset) begin
      rrPtr <= '0;
    end else if (issueFire) begin
      rrPtr <= IdWidth'(rrNext(int'(granted), NUM_PORTS));
    end
  end

  // Pin the grant while the memory stalls so address and data stay stable.
  always_ff @(posedge clock) begin
    if (reset) begin
      lockValid <= 1'b0;
      lockId    <= '0;
    end else begin
      lockValid <= mem_st_valid & !mem_st_ready;
      if (mem_st_valid && !mem_st_ready) lockId <= granted;
    end
  end

  handshake_store_tag_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .ID_WIDTH(IdWidth)
  ) tagFifo (
    .clock (clock),
    .reset (reset),
    .push  (issueFire),
    .pushId(granted),
    .pop   (doneFire),
    .headId(headId),
    .full  (tagFull),
    .empty (tagEmpty)
  );

  // Steer the memory completion to the requester at the head of the tags.
  always_comb begin
    req_stDone_valid = '0;
    if (!tagEmpty) req_stDone_valid[headId] = mem_stDone_valid;
  end

  assign mem_stDone_ready = !tagEmpty & req_stDone_ready[headId];
  assign doneFire         = mem_stDone_valid & mem_stDone_ready;

  // Sticky flag for a completion that matches no issued write.
  always_ff @(posedge clock) begin
    if (reset) begin
      protocol_error <= 1'b0;
    end else if (mem_stDone_valid && tagEmpty) begin
      protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_handshake_store_arbiter.sv
// Bench for handshake_store_arbiter: requesters and memory are modelled in
// the bench, a reference model predicts every cycle, a monitor compares.
module tb_handshake_store_arbiter;

  localparam int NP = 5;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int MO = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [NP-1:0][DW-1:0] req_stData;
  logic [NP-1:0][AW-1:0] req_stAddr;
  logic [NP-1:0] req_stData_valid, req_stAddr_valid;
  logic [NP-1:0] req_stData_ready, req_stAddr_ready;
  logic [NP-1:0] req_stDone_valid, req_stDone_ready;
  logic [DW-1:0] mem_stData;
  logic [AW-1:0] mem_stAddr;
  logic mem_st_valid, mem_st_ready, mem_stDone_valid, mem_stDone_ready;
  logic protocol_error;

  handshake_store_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_stData(req_stData), .req_stData_valid(req_stData_valid),
    .req_stData_ready(req_stData_ready),
    .req_stAddr(req_stAddr), .req_stAddr_valid(req_stAddr_valid),
    .req_stAddr_ready(req_stAddr_ready),
    .req_stDone_valid(req_stDone_valid), .req_stDone_ready(req_stDone_ready),
    .mem_stData(mem_stData), .mem_stAddr(mem_stAddr),
    .mem_st_valid(mem_st_valid), .mem_st_ready(mem_st_ready),
    .mem_stDone_valid(mem_stDone_valid), .mem_stDone_ready(mem_stDone_ready),
    .protocol_error(protocol_error)
  );

  // ---------------- bench-side environment and reference model ----------------
  bit            reqPend [NP];
  logic [AW-1:0] reqAddr [NP];
  logic [DW-1:0] reqData [NP];
  bit            memReady;
  bit            doneValid;
  logic [NP-1:0] doneReady;

  int rrPtr;
  int lockId;
  int tagQ[$];
  bit protoErr;

  typedef struct {
    logic          stValid;
    logic [NP-1:0] readyVec;
    logic [NP-1:0] doneVec;
    logic          memDoneReady;
    logic          protoErr;
  } cyc_t;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } iss_t;

  cyc_t cycQ[$];
  iss_t issQ[$];

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic newReq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqPend[i] = 1'b1;
    reqAddr[i] = a;
    reqData[i] = d;
  endtask

  task automatic randReq(input int i);
    newReq(i, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // One cycle: drive inputs, predict outputs, advance model over the edge.
  task automatic step();
    int   grant;
    int   head;
    bit   stValid, fire, doneFire;
    cyc_t c;
    iss_t e;
    for (int i = 0; i < NP; i++) begin
      req_stAddr_valid[i] = reqPend[i];
      req_stData_valid[i] = reqPend[i];
      req_stAddr[i]       = reqAddr[i];
      req_stData[i]       = reqData[i];
    end
    mem_st_ready     = memReady;
    mem_stDone_valid = doneValid;
    req_stDone_ready = doneReady;

    grant = -1;
    if (lockId >= 0 && reqPend[lockId]) grant = lockId;
    else
      for (int k = 0; k < NP; k++)
        if (grant < 0 && reqPend[(rrPtr + k) % NP]) grant = (rrPtr + k) % NP;
    stValid  = (grant >= 0) && (tagQ.size() < MO);
    fire     = stValid && memReady;
    head     = (tagQ.size() > 0) ? tagQ[0] : -1;
    doneFire = doneValid && (head >= 0) && doneReady[head];

    c.stValid      = stValid;
    c.readyVec     = fire ? (NP'(1) << grant) : '0;
    c.doneVec      = (doneValid && head >= 0) ? (NP'(1) << head) : '0;
    c.memDoneReady = (head >= 0) && doneReady[head];
    c.protoErr     = protoErr;
    cycQ.push_back(c);
    if (fire) begin
      e.id = grant; e.addr = reqAddr[grant]; e.data = reqData[grant];
      issQ.push_back(e);
    end

    @(posedge clock);
    if (doneFire) void'(tagQ.pop_front());
    if (fire) begin
      tagQ.push_back(grant);
      rrPtr = (grant + 1) % NP;
      reqPend[grant] = 1'b0;
      lockId = -1;
    end else if (stValid) begin
      lockId = grant;
    end else begin
      lockId = -1;
    end
    if (doneValid && head < 0) protoErr = 1'b1;
    if (doneFire) doneValid = 1'b0;
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    for (int i = 0; i < NP; i++) reqPend[i] = 1'b0;
    req_stAddr_valid = '0; req_stData_valid = '0;
    req_stAddr = '0; req_stData = '0;
    memReady = 1'b0; doneValid = 1'b0; doneReady = '0;
    mem_st_ready = 1'b0; mem_stDone_valid = 1'b0; req_stDone_ready = '0;
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_addr_ready", 64'(req_stAddr_ready), 64'(0));
    check("rst_data_ready", 64'(req_stData_ready), 64'(0));
    check("rst_done_valid", 64'(req_stDone_valid), 64'(0));
    check("rst_st_valid", 64'(mem_st_valid), 64'(0));
    check("rst_mem_done_ready", 64'(mem_stDone_ready), 64'(0));
    check("rst_protocol_error", 64'(protocol_error), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    rrPtr = 0; lockId = -1; tagQ.delete(); protoErr = 1'b0;
    cycQ.delete(); issQ.delete();
  endtask

  // Return completions promptly with no new requests until tags drain.
  task automatic drain();
    doneReady = '1;
    for (int c = 0; c < 8; c++) begin
      if (!doneValid && tagQ.size() > 0) doneValid = 1'b1;
      step();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  cyc_t mc;
  iss_t me;
  always @(negedge clock) begin
    if (!reset && cycQ.size() > 0) begin
      mc = cycQ.pop_front();
      check("st_valid", 64'(mem_st_valid), 64'(mc.stValid));
      check("addr_ready", 64'(req_stAddr_ready), 64'(mc.readyVec));
      check("data_ready", 64'(req_stData_ready), 64'(mc.readyVec));
      check("done_valid", 64'(req_stDone_valid), 64'(mc.doneVec));
      check("mem_done_ready", 64'(mem_stDone_ready), 64'(mc.memDoneReady));
      check("protocol_error", 64'(protocol_error), 64'(mc.protoErr));
      if (mem_st_valid && mem_st_ready) begin
        if (issQ.size() == 0) begin
          check("issue_unexpected", 64'(1), 64'(0));
        end else begin
          me = issQ.pop_front();
          check("issue_addr", 64'(mem_stAddr), 64'(me.addr));
          check("issue_data", 64'(mem_stData), 64'(me.data));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    memReady = 1'b0; doneValid = 1'b0; doneReady = '0;
    rrPtr = 0; lockId = -1; protoErr = 1'b0;
    for (int i = 0; i < NP; i++) begin
      reqPend[i] = 1'b0; reqAddr[i] = '0; reqData[i] = '0;
    end
    doReset();

    // Single requester 2 writes 0xA at address 1.
    doneReady = '1; memReady = 1'b1;
    newReq(2, 64'h1, 64'hA);
    step();
    doneValid = 1'b1;
    step();
    step();

    // Every requester always valid, memory always ready, done next cycle.
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NP; i++) if (!reqPend[i]) randReq(i);
      if (!doneValid && tagQ.size() > 0) doneValid = 1'b1;
      step();
    end
    for (int i = 0; i < NP; i++) reqPend[i] = 1'b0;
    drain();

    // Memory stalls with requester 3 granted; others arrive meanwhile.
    newReq(2, {$urandom, $urandom}, {$urandom, $urandom});
    step();
    drain();
    memReady = 1'b0;
    randReq(3);
    step();
    randReq(1); randReq(4); randReq(0);
    step();
    step();
    memReady = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (!doneValid && tagQ.size() > 0) doneValid = 1'b1;
      step();
    end
    drain();

    // Completions withheld until the tag buffer fills, then released.
    for (int i = 0; i < NP; i++) randReq(i);
    for (int c = 0; c < 4; c++) step();
    doneValid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (!doneValid && tagQ.size() > 0) doneValid = 1'b1;
      step();
    end
    for (int i = 0; i < NP; i++) reqPend[i] = 1'b0;
    drain();

    // Completion owner not ready for two cycles.
    randReq(1);
    step();
    randReq(4);
    step();
    doneReady = '1; doneReady[1] = 1'b0; doneValid = 1'b1;
    step();
    step();
    doneReady = '1;
    drain();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (!reqPend[i] && $urandom_range(0, 2) == 0) randReq(i);
        else if (reqPend[i] && lockId != i && $urandom_range(0, 63) == 0) reqPend[i] = 1'b0;
      end
      memReady  = ($urandom_range(0, 3) != 0);
      doneReady = NP'($urandom) | NP'($urandom);
      if (!doneValid && tagQ.size() > 0 && $urandom_range(0, 2) != 0) doneValid = 1'b1;
      step();
    end

    // Reset with writes in flight, then a late completion.
    doReset();
    doneReady = '1;
    doneValid = 1'b1;
    step();
    doneValid = 1'b0;
    step();
    step();
    step();
    doReset();

    check("issue_queue_empty", 64'(issQ.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
